// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the iteration-counter sizing helper.
package seq_div_pkg;

  localparam int unsigned DIV_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..w-1; keep at least one bit for degenerate widths.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_div9_addsub_co.sv
// Combinational W-bit subtractor a - b in propagate/generate form,
// exposing the borrow out of the top bit for trial subtraction.
module addsub_co #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] bn;
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;

  // a - b == a + ~b + 1, so the chain starts with carry-in set.
  assign bn = ~b;
  assign p  = a ^ bn;
  assign g  = a & bn;

  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign diff   = p ^ c[W-1:0];
  assign borrow = ~c[W];

endmodule

// File: rtl/seq_div9.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes on request and result.
module seq_div9
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned RW = WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [RW-1:0]    r;
  logic [CW-1:0]    cnt;
  logic             dz;

  logic [RW-1:0]    s;
  logic [RW-1:0]    t;
  logic             borrow;
  logic [RW-1:0]    r_next;
  logic [WIDTH-1:0] q_next;

  // Shift the partial remainder left and bring in the next dividend bit;
  // R stays below D between steps, so its top bit drops out here.
  assign s = RW'({r, q[WIDTH-1]});

  addsub_co #(
    .W(RW)
  ) u_sub (
    .a     (s),
    .b     ({1'b0, d}),
    .diff  (t),
    .borrow(borrow)
  );

  assign r_next = borrow ? s : t;
  assign q_next = {q[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      d         <= '0;
      r         <= '0;
      cnt       <= '0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q     <= dividend;
            d     <= divisor;
            r     <= '0;
            cnt   <= '0;
            dz    <= (divisor == '0);
            state <= CALC;
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
            div_zero  <= dz;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_div9.sv
// Self-checking bench for seq_div9: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_seq_div9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [8:0] dividend = '0;
  logic [8:0] divisor = '0;
  logic       in_ready;
  logic       out_valid;
  logic [8:0] quotient;
  logic [8:0] remainder;
  logic       div_zero;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seq_div9 #(.WIDTH(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division; divide-by-zero yields all ones and the dividend.
  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int dz);
    if (b == 0) begin
      q = 511; r = a; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle model: busy from the accepting edge; result visible from edge accept+9
  // until the edge after out_ready is seen high with the result valid.
  bit m_busy = 1'b0;
  bit p_acc = 1'b0;
  bit p_rel = 1'b0;
  int m_due = 0;
  int m_a = 0;
  int m_b = 0;
  int lq = 0;
  int lr = 0;
  int ldz = 0;

  always @(negedge clk) begin
    bit exp_vld;
    if (!rst_n) begin
      m_busy = 1'b0; p_acc = 1'b0; p_rel = 1'b0;
      lq = 0; lr = 0; ldz = 0;
    end else begin
      if (p_rel) begin m_busy = 1'b0; p_rel = 1'b0; end
      if (p_acc) begin m_busy = 1'b1; m_due = cyc + 9; p_acc = 1'b0; end
      if (m_busy && cyc == m_due) ref_div(m_a, m_b, lq, lr, ldz);
    end
    exp_vld = m_busy && (cyc >= m_due);
    chk("in_ready", int'(in_ready), int'(!m_busy));
    chk("out_valid", int'(out_valid), int'(exp_vld));
    chk("quotient", int'(quotient), lq);
    chk("remainder", int'(remainder), lr);
    chk("div_zero", int'(div_zero), ldz);
    if (rst_n) begin
      if (!m_busy && in_valid) begin
        p_acc = 1'b1; m_a = int'(dividend); m_b = int'(divisor);
      end
      if (exp_vld && out_ready) p_rel = 1'b1;
    end
  end

  // Issue one request from IDLE, check latency and result against the given
  // expectations, hold out_ready low for 'hold' cycles, then accept.
  task automatic run_div(input int a, input int b, input int eq, input int er,
                         input int edz, input int hold);
    int lat;
    @(posedge clk); #1;
    chk("ready_before_req", int'(in_ready), 1);
    in_valid = 1'b1; dividend = 9'(a); divisor = 9'(b); out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 9'($urandom); divisor = 9'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 9);
    chk("res_q", int'(quotient), eq);
    chk("res_r", int'(remainder), er);
    chk("res_dz", int'(div_zero), edz);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = 9'($urandom); divisor = 9'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_ready", int'(in_ready), 0);
      chk("hold_q", int'(quotient), eq);
      chk("hold_r", int'(remainder), er);
      chk("hold_dz", int'(div_zero), edz);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("released_valid", int'(out_valid), 0);
    chk("released_ready", int'(in_ready), 1);
  endtask

  initial begin
    int q, r, dz, a, b;

    ref_div(200, 7, q, r, dz);
    chk("model_200_7_q", q, 28); chk("model_200_7_r", r, 4);
    ref_div(300, 0, q, r, dz);
    chk("model_300_0_q", q, 511); chk("model_300_0_r", r, 300); chk("model_300_0_dz", dz, 1);
    ref_div(450, 13, q, r, dz);
    chk("model_450_13_q", q, 34); chk("model_450_13_r", r, 8);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    rst_n = 1'b1;

    run_div(200, 7, 28, 4, 0, 0);
    run_div(511, 1, 511, 0, 0, 0);
    run_div(5, 9, 0, 5, 0, 0);
    run_div(511, 511, 1, 0, 0, 0);
    run_div(0, 3, 0, 0, 0, 0);
    run_div(300, 0, 511, 300, 1, 0);
    run_div(200, 7, 28, 4, 0, 5);
    run_div(100, 10, 10, 0, 0, 0);

    // Reset four edges into CALC: no result may appear afterwards.
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = 9'd450; divisor = 9'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_quotient", int'(quotient), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("postrst_no_valid", int'(out_valid), 0);
    end
    run_div(450, 13, 34, 8, 0, 0);

    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 7))
        0: a = 0;
        1: a = 511;
        default: a = int'($urandom_range(0, 511));
      endcase
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 511;
        2: b = 1;
        default: b = int'($urandom_range(0, 511));
      endcase
      ref_div(a, b, q, r, dz);
      run_div(a, b, q, r, dz, int'($urandom_range(0, 1)));
      if (b != 0) begin
        chk("sweep_identity", int'(quotient) * b + int'(remainder), a);
        chk("sweep_rem_lt_div", int'(int'(remainder) < b), 1);
      end
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
